pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Two-channel PWM decoder; the inverse of the motor drive block. Measures the high time of each incoming PWM line and recovers the 6-bit command value per channel.
- Sits on the feedback and loopback path, between external PWM pins (or drive outputs) and control logic.
- Reports a value once per completed PWM period.
- Flags loss of signal when no period completes within a timeout.

Parameters:
- STEP_CYCLES, 100, clock cycles per duty LSB (drive high time = duty * STEP_CYCLES).
- TIMEOUT_CYCLES, 16384, cycles without an accepted rising edge before a channel is declared lost.
- FILTER_CYCLES, 4, stable-sample count for the glitch filter (used only with PWM_CAPTURE_FILTER_EN).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- pwm_in_0  input  1  PWM line, channel 0; asynchronous to clk.
- pwm_in_1  input  1  PWM line, channel 1; asynchronous to clk.
- duty_out_0  output  6  last decoded duty, channel 0.
- duty_out_1  output  6  last decoded duty, channel 1.
- valid_0  output  1  one-cycle pulse when duty_out_0 is updated from a complete period.
- valid_1  output  1  as valid_0, for channel 1.
- lost_0  output  1  channel 0 has no valid signal.
- lost_1  output  1  channel 1 has no valid signal.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - duty_out_* = 0, valid_* = 0, lost_* = 1.
  - All counters = 0.
  - State = WAIT_RISE.
  - Synchronizer flops = 0.
- Channel independence: the two channels are identical and independent. Below, the rules are for one channel.
- Input path:
  - 2-flop synchronizer, then a 1-flop delayed copy for edge detect.
  - A pin edge at cycle N is acted on at cycle N+3.
- States:
  - WAIT_RISE: no period reference yet. On a rising edge, go to HIGH and clear step_cnt, units and since_rise.
  - HIGH: each cycle step_cnt++. When step_cnt == STEP_CYCLES-1, step_cnt wraps to 0 and units++, saturating at 63. On a falling edge, hold_units <= units and go to LOW.
  - LOW: on a rising edge the period is complete:
    - duty_out <= hold_units, valid <= 1 for one cycle, lost <= 0.
    - Clear step_cnt, units and since_rise, then go to HIGH.
- Arithmetic:
  - Decoded duty = floor(high_cycles / STEP_CYCLES), saturated to 63.
  - step_cnt is wide enough for STEP_CYCLES-1.
  - since_rise is wide enough for TIMEOUT_CYCLES.
- Timeout:
  - since_rise increments each cycle in HIGH and LOW, saturating.
  - When it reaches TIMEOUT_CYCLES: lost <= 1, duty_out <= 63 if the synchronized line is high, else 0. No valid pulse. State -> WAIT_RISE.
- After reset or timeout, the first rising edge only starts a measurement. The first valid pulse comes at the second rising edge.
- Simultaneous events:
  - A rising edge on the same cycle the timeout would fire: the edge wins (period completes, no lost).
  - Reset overrides everything.
- Reset mid-operation: the in-progress measurement is discarded and outputs return to reset values.
- valid is never asserted during reset or in the cycle reset deasserts.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined: a per-channel glitch filter follows the synchronizer. The filtered line changes only after the synchronized input has differed from it for FILTER_CYCLES consecutive cycles. Shorter pulses are ignored, and all edge latencies grow by FILTER_CYCLES.
- Undefined: no filter. Every synchronized edge is acted on. FILTER_CYCLES is unused.

Test Plan:
- Nominal decode: ch0 high 2000 cycles / period 6400, repeated. 3 cycles after the 2nd rising edge, valid_0 pulses once and duty_out_0 = 20, lost_0 = 0. It pulses again every 6400 cycles.
- Floor rounding and independence: ch0 high 2099/6400 -> duty_out_0 = 20. At the same time ch1 high 6300/6400 -> duty_out_1 = 63. The valid pulses are independent per channel.
- Saturation: ch1 high 6700 / period 7000 -> duty_out_1 = 63, no wrap.
- Timeout:
  - Ch0 established at duty 10, then pin held low: 16384 cycles after the last accepted rising edge, lost_0 = 1, duty_out_0 = 0, no valid.
  - Same with pin held high: duty_out_0 = 63.
- Reset mid-HIGH: assert reset 1 cycle during high time -> duty_out = 0, lost = 1. The next valid pulse appears only after two more rising edges.
- Filter (macro defined): a 2-cycle high glitch during low time produces no edge and no change to duty. With the macro undefined, the same glitch completes a period early and gives a valid with the measured value.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: two-channel PWM decoder. It measures the high time of each
// PWM line and recovers the 6-bit duty value. A new value is reported once
// per completed period. A channel is flagged as lost when no rising edge is
// accepted within TIMEOUT_CYCLES.
// Optional build macro PWM_CAPTURE_FILTER_EN: adds a per-channel glitch
// filter of FILTER_CYCLES stable samples after the synchronizer.

module pwm_capture_ch #(
    parameter int unsigned STEP_CYCLES    = 100,
    parameter int unsigned TIMEOUT_CYCLES = 16384,
    parameter int unsigned FILTER_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [5:0] duty_out,
    output logic       valid,
    output logic       lost
);

    localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    // Edge detection stays disarmed until every stage in front of the
    // delayed copy holds a real post-reset sample. Otherwise a line that is
    // already high when reset releases would look like a fresh rising edge.
`ifdef PWM_CAPTURE_FILTER_EN
    localparam logic [2:0] PRIME_DEPTH = 3'd4;
`else
    localparam logic [2:0] PRIME_DEPTH = 3'd3;
`endif

    typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

    state_t          state, state_next;
    logic            sync_1, sync_2, line, line_d;
    logic [2:0]      prime_cnt;
    logic            primed, rise, fall;
    logic [SW-1:0]   step_cnt;
    logic [5:0]      units, units_inc, hold_units;
    logic [TW-1:0]   since_rise;
    logic            wrap, timeout_hit;
    logic            start_meas, capture, latch_hold, time_out;

    // Two-flop synchronizer, delayed copy for edge detect, and the arming counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            line_d    <= 1'b0;
            prime_cnt <= '0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
            line_d <= line;
            if (!primed)
                prime_cnt <= prime_cnt + 3'd1;
        end
    end

    assign primed = (prime_cnt == PRIME_DEPTH);

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
    logic [FW-1:0] filt_cnt;

    // Glitch filter: follow the synchronized line only after it has differed for FILTER_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            line     <= 1'b0;
            filt_cnt <= '0;
        end else if (!primed) begin
            line     <= sync_2;
            filt_cnt <= '0;
        end else if (sync_2 != line) begin
            if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                line     <= sync_2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end
`else
    assign line = sync_2;

    // FILTER_CYCLES shapes only the filtered build.
    if (FILTER_CYCLES == 0) begin : g_filter_unused
    end
`endif

    assign rise = primed & line & ~line_d;
    assign fall = primed & ~line & line_d;

    assign wrap        = (step_cnt == SW'(STEP_CYCLES - 1));
    assign units_inc   = (wrap && units != 6'd63) ? units + 6'd1 : units;
    assign timeout_hit = (since_rise == TW'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= WAIT_RISE;
        else
            state <= state_next;
    end

    // Next-state logic; in LOW a rising edge beats a coincident timeout
    always_comb begin
        state_next = state;
        case (state)
            WAIT_RISE: if (rise) state_next = HIGH;
            HIGH: begin
                if (timeout_hit)
                    state_next = WAIT_RISE;
                else if (fall)
                    state_next = LOW;
            end
            LOW: begin
                if (rise)
                    state_next = HIGH;
                else if (timeout_hit)
                    state_next = WAIT_RISE;
            end
            default: state_next = WAIT_RISE;
        endcase
    end

    // Datapath strobes derived from state and line events
    always_comb begin
        start_meas = 1'b0;
        capture    = 1'b0;
        latch_hold = 1'b0;
        time_out   = 1'b0;
        case (state)
            WAIT_RISE: start_meas = rise;
            HIGH: begin
                time_out   = timeout_hit;
                latch_hold = fall & ~timeout_hit;
            end
            LOW: begin
                capture    = rise;
                start_meas = rise;
                time_out   = timeout_hit & ~rise;
            end
            default: ;
        endcase
    end

    // Measurement counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt   <= '0;
            units      <= '0;
            hold_units <= '0;
            since_rise <= '0;
            duty_out   <= '0;
            valid      <= 1'b0;
            lost       <= 1'b1;
        end else begin
            valid <= capture;

            if (start_meas) begin
                step_cnt <= '0;
                units    <= '0;
            end else if (state == HIGH) begin
                step_cnt <= wrap ? '0 : step_cnt + 1'b1;
                units    <= units_inc;
            end

            // The falling-edge cycle is itself a high cycle, so it is counted in.
            if (latch_hold)
                hold_units <= units_inc;

            if (start_meas || time_out)
                since_rise <= '0;
            else if (state != WAIT_RISE && !timeout_hit)
                since_rise <= since_rise + 1'b1;

            if (capture) begin
                duty_out <= hold_units;
                lost     <= 1'b0;
            end else if (time_out) begin
                duty_out <= {6{line}};
                lost     <= 1'b1;
            end
        end
    end

endmodule

module pwm_capture #(
    parameter int unsigned STEP_CYCLES    = 100,
    parameter int unsigned TIMEOUT_CYCLES = 16384,
    parameter int unsigned FILTER_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in_0,
    input  logic       pwm_in_1,
    output logic [5:0] duty_out_0,
    output logic [5:0] duty_out_1,
    output logic       valid_0,
    output logic       valid_1,
    output logic       lost_0,
    output logic       lost_1
);

    pwm_capture_ch #(
        .STEP_CYCLES    (STEP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_CYCLES  (FILTER_CYCLES)
    ) u_ch0 (
        .clk      (clk),
        .reset    (reset),
        .pwm_in   (pwm_in_0),
        .duty_out (duty_out_0),
        .valid    (valid_0),
        .lost     (lost_0)
    );

    pwm_capture_ch #(
        .STEP_CYCLES    (STEP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_CYCLES  (FILTER_CYCLES)
    ) u_ch1 (
        .clk      (clk),
        .reset    (reset),
        .pwm_in   (pwm_in_1),
        .duty_out (duty_out_1),
        .valid    (valid_1),
        .lost     (lost_1)
    );

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed-vector bench for pwm_capture. Each period vector
// gives the high and low time, together with the duty value that its rising
// edge must report (-1 means no valid pulse is allowed at that edge).
module tb_pwm_capture;

    localparam int STEP    = 100;
    localparam int TIMEOUT = 16384;
    localparam int FILTER  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int OFS = 3 + FILTER;
`else
    localparam int OFS = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in_0, pwm_in_1;
    logic [5:0] duty_out_0, duty_out_1;
    logic       valid_0, valid_1, lost_0, lost_1;

    int n_vec  = 0;
    int n_miss = 0;
    int act_valid [2] = '{0, 0};
    int exp_valid [2] = '{0, 0};

    pwm_capture #(
        .STEP_CYCLES    (STEP),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_CYCLES  (FILTER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in_0   (pwm_in_0),
        .pwm_in_1   (pwm_in_1),
        .duty_out_0 (duty_out_0),
        .duty_out_1 (duty_out_1),
        .valid_0    (valid_0),
        .valid_1    (valid_1),
        .lost_0     (lost_0),
        .lost_1     (lost_1)
    );

    always #5 clk = ~clk;

    // count every valid pulse per channel
    always @(negedge clk) begin
        if (valid_0) act_valid[0] = act_valid[0] + 1;
        if (valid_1) act_valid[1] = act_valid[1] + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int get_valid(input int ch);
        return (ch == 0) ? int'(valid_0) : int'(valid_1);
    endfunction

    function automatic int get_duty(input int ch);
        return (ch == 0) ? int'(duty_out_0) : int'(duty_out_1);
    endfunction

    function automatic int get_lost(input int ch);
        return (ch == 0) ? int'(lost_0) : int'(lost_1);
    endfunction

    task automatic set_pin(input int ch, input logic v);
        if (ch == 0) pwm_in_0 = v;
        else         pwm_in_1 = v;
    endtask

    // One period: rise now (at a negedge), high for 'high' cycles, then low for 'low' cycles.
    task automatic drive_period(input int ch, input int high, input int low,
                                input int exp, input bit drop);
        set_pin(ch, 1'b1);
        if (exp >= 0) exp_valid[ch]++;
        for (int i = 1; i <= high + low; i++) begin
            @(negedge clk);
            if (i == high && drop) set_pin(ch, 1'b0);
            if (i == OFS) begin
                if (exp >= 0) begin
                    check($sformatf("ch%0d valid", ch), get_valid(ch), 1);
                    check($sformatf("ch%0d duty", ch), get_duty(ch), exp);
                    check($sformatf("ch%0d lost", ch), get_lost(ch), 0);
                end else begin
                    check($sformatf("ch%0d no-valid", ch), get_valid(ch), 0);
                end
            end
            if (i == OFS + 1)
                check($sformatf("ch%0d valid-1cyc", ch), get_valid(ch), 0);
        end
    endtask

    // Establish duty 10, then stop toggling; 'level' is the held pin level.
    task automatic timeout_run(input int ch, input int exp_prev, input bit level);
        drive_period(ch, 1000, 5400, exp_prev, 1'b1);
        drive_period(ch, 1000, 0, 10, !level);
        repeat (TIMEOUT - 1000 - 20) @(negedge clk);
        check($sformatf("ch%0d pre-timeout lost", ch), get_lost(ch), 0);
        check($sformatf("ch%0d pre-timeout duty", ch), get_duty(ch), 10);
        repeat (40) @(negedge clk);
        check($sformatf("ch%0d timeout lost", ch), get_lost(ch), 1);
        check($sformatf("ch%0d timeout duty", ch), get_duty(ch), level ? 63 : 0);
    endtask

    initial begin
        reset    = 1'b1;
        pwm_in_0 = 1'b0;
        pwm_in_1 = 1'b0;
        repeat (5) @(negedge clk);
        check("rst duty0", int'(duty_out_0), 0);
        check("rst duty1", int'(duty_out_1), 0);
        check("rst valid0", int'(valid_0), 0);
        check("rst valid1", int'(valid_1), 0);
        check("rst lost0", int'(lost_0), 1);
        check("rst lost1", int'(lost_1), 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst-release valid0", int'(valid_0), 0);
        repeat (10) @(negedge clk);

        // nominal, floor rounding and saturation, then timeout low (ch0) / high (ch1)
        fork
            begin
                drive_period(0, 2000, 4400, -1, 1'b1);
                drive_period(0, 2000, 4400, 20, 1'b1);
                drive_period(0, 2000, 4400, 20, 1'b1);
                drive_period(0, 2099, 4301, 20, 1'b1);
                drive_period(0, 2099, 4301, 20, 1'b1);
                timeout_run(0, 20, 1'b0);
            end
            begin
                drive_period(1, 6300, 100, -1, 1'b1);
                drive_period(1, 6300, 100, 63, 1'b1);
                drive_period(1, 6700, 300, 63, 1'b1);
                drive_period(1, 6700, 300, 63, 1'b1);
                timeout_run(1, 63, 1'b1);
            end
        join
        pwm_in_1 = 1'b0;
        repeat (20) @(negedge clk);
        check("post-timeout lost0", int'(lost_0), 1);
        check("post-timeout lost1", int'(lost_1), 1);

        // reset in the middle of a high phase
        drive_period(0, 1000, 2000, -1, 1'b1);
        drive_period(0, 1000, 2000, 10, 1'b1);
        drive_period(0, 500, 0, 10, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst duty0", int'(duty_out_0), 0);
        check("midrst lost0", int'(lost_0), 1);
        check("midrst valid0", int'(valid_0), 0);
        check("midrst duty1", int'(duty_out_1), 0);
        check("midrst lost1", int'(lost_1), 1);
        repeat (500) @(negedge clk);
        pwm_in_0 = 1'b0;
        repeat (2000) @(negedge clk);
        drive_period(0, 1000, 2000, -1, 1'b1);
        drive_period(0, 1000, 2000, 10, 1'b1);

        // 2-cycle glitch during low time on ch1
        drive_period(1, 1000, 2000, -1, 1'b1);
        drive_period(1, 1000, 500, 10, 1'b1);
`ifdef PWM_CAPTURE_FILTER_EN
        drive_period(1, 2, 1500, -1, 1'b1);
        drive_period(1, 1000, 1000, 10, 1'b1);
`else
        drive_period(1, 2, 1500, 10, 1'b1);
        drive_period(1, 1000, 1000, 0, 1'b1);
`endif
        repeat (10) @(negedge clk);

        check("valid count ch0", act_valid[0], exp_valid[0]);
        check("valid count ch1", act_valid[1], exp_valid[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
